// File: rtl/btb_bimodal.sv
`default_nettype none
// ============================================================================
//  Module   : btb_bimodal
//  Purpose  : Fetch-stage branch predictor. Direct-mapped branch target
//             buffer with one 2-bit saturating direction counter per entry.
//             Lookup is combinational on the fetch PC; training comes from
//             branch outcomes resolved in execute.
//  Ports    :
//    clk        - clock, all state updates on rising edge
//    rstn       - asynchronous active-low reset
//    stall      - pipeline stall, blocks table updates
//    clr        - synchronous invalidate-all (fence.i)
//    fpc        - fetch PC to predict for
//    pred       - 1 = predicted taken
//    next_pc    - predicted next fetch PC
//    hit        - fpc matched a valid entry
//    upd_valid  - a resolved control-flow instruction is presented
//    upd_pc     - PC of the resolved instruction
//    upd_taken  - actual outcome
//    upd_target - actual taken target (bit 0 ignored)
//  Revision : 1.0 - initial release
// ============================================================================
module btb_bimodal #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        clr,
  input  logic [31:0] fpc,
  output logic        pred,
  output logic [31:0] next_pc,
  output logic        hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_MAX     = 2'b11;
  localparam logic [1:0] CTR_MIN     = 2'b00;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [30:0]        tgt_q [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup (no bypass: same-cycle updates are seen only after the edge)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;

  assign f_idx   = fpc[IDX_W+1:2];
  assign f_tag   = fpc[31:IDX_W+2];
  assign hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred    = hit && ctr_q[f_idx][1];
  assign next_pc = pred ? {tgt_q[f_idx], 1'b0} : (fpc + 32'd4);

  // ---------------------------------------------------------------------------
  // Update
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             do_upd;
  logic             wr_data;

  assign u_idx  = upd_pc[IDX_W+1:2];
  assign u_tag  = upd_pc[31:IDX_W+2];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign do_upd = upd_valid && !stall && !clr;

  // Any taken update writes tag and target: on a hit the tag rewrite is
  // idempotent, on a miss it is the allocation.
  assign wr_data = do_upd && upd_taken;

  // Valid bits and counters carry the reset state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WEAK_NT;
      end
    end else if (clr) begin
      valid_q <= '0;
    end else if (do_upd) begin
      if (u_hit) begin
        if (upd_taken) begin
          if (ctr_q[u_idx] != CTR_MAX) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
        end else begin
          if (ctr_q[u_idx] != CTR_MIN) ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= CTR_WEAK_T;
      end
    end
  end

  // Tag and target storage needs no reset; it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (wr_data) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target[31:1];
    end
  end

  // Byte-offset bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, fpc[1:0], upd_pc[1:0], upd_target[0]};

endmodule
`default_nettype wire

// File: tb/tb_btb_bimodal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btb_bimodal
//  Purpose  : Self-checking bench for btb_bimodal: directed scenarios plus
//             randomized training against a behavioural table model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btb_bimodal;

  localparam int ENT  = 16;
  localparam int IDXW = 4;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        clr;
  logic [31:0] fpc;
  logic        pred;
  logic [31:0] next_pc;
  logic        hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int total  = 0;
  int passed = 0;

  btb_bimodal #(.ENTRIES(ENT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .clr        (clr),
    .fpc        (fpc),
    .pred       (pred),
    .next_pc    (next_pc),
    .hit        (hit),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: per slot, the owning PC's upper bits, target and a
  // counter kept as a plain integer 0..3.
  // ---------------------------------------------------------------------------
  bit          m_valid [ENT];
  logic [31:0] m_key   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic logic [31:0] key(input logic [31:0] pc);
    return pc >> (IDXW + 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic eh,
                                       output logic ep, output logic [31:0] en);
    int s;
    s  = slot(pc);
    eh = m_valid[s] && (m_key[s] == key(pc));
    ep = eh && (m_ctr[s] >= 2);
    en = ep ? m_tgt[s] : pc + 32'd4;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tgt);
    int s;
    s = slot(pc);
    if (m_valid[s] && m_key[s] == key(pc)) begin
      if (tk) begin
        m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        m_tgt[s] = tgt & 32'hFFFF_FFFE;
      end else begin
        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
      end
    end else if (tk) begin
      m_valid[s] = 1'b1;
      m_key[s]   = key(pc);
      m_tgt[s]   = tgt & 32'hFFFF_FFFE;
      m_ctr[s]   = 2;
    end
  endfunction

  // One clock; the model follows whatever inputs are presented at the edge.
  task automatic tick();
    @(posedge clk);
    if (rstn) begin
      if (clr) begin
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
      end else if (upd_valid && !stall) begin
        model_update(upd_pc, upd_taken, upd_target);
      end
    end
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    upd_valid = 1'b0;
    stall = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #3;
    rstn = 1'b1;
    #2;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < ENT; i++) begin
      logic [31:0] pc;
      pc  = 32'h100 + 32'(i * 4);
      fpc = pc;
      #1;
      total++;
      if ({hit, pred, next_pc} !== {1'b0, 1'b0, pc + 32'd4}) begin
        $display("FAIL reset_lookup idx=%0d got hit=%b pred=%b npc=%h want 0 0 %h",
                 i, hit, pred, next_pc, pc + 32'd4);
      end else passed++;
    end
  endtask

  task automatic test_alloc();
    do_reset();
    upd(32'h100, 1'b1, 32'h200);
    fpc = 32'h100; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b1, 32'h200}) begin
      $display("FAIL alloc got hit=%b pred=%b npc=%h want 1 1 00000200", hit, pred, next_pc);
    end else passed++;
    upd(32'h100, 1'b1, 32'h200);   // ctr 11
    upd(32'h100, 1'b0, 32'h0);     // ctr 10
    fpc = 32'h100; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b1, 32'h200}) begin
      $display("FAIL hyst_one_nt got hit=%b pred=%b npc=%h want 1 1 00000200", hit, pred, next_pc);
    end else passed++;
    upd(32'h100, 1'b0, 32'h0);     // ctr 01
    fpc = 32'h100; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b0, 32'h104}) begin
      $display("FAIL hyst_two_nt got hit=%b pred=%b npc=%h want 1 0 00000104", hit, pred, next_pc);
    end else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);     // 11 -> 10
    fpc = 32'h100; #1;
    total++;
    if (pred !== 1'b1) begin
      $display("FAIL sat_high got pred=%b want 1", pred);
    end else passed++;
    upd(32'h100, 1'b1, 32'h200);   // back to 11
    for (int i = 0; i < 4; i++) upd(32'h100, 1'b0, 32'h0);  // 00
    fpc = 32'h100; #1;
    total++;
    if ({hit, pred} !== 2'b10) begin
      $display("FAIL sat_low got hit=%b pred=%b want 1 0", hit, pred);
    end else passed++;
    upd(32'h100, 1'b0, 32'h0);     // stays 00
    upd(32'h100, 1'b1, 32'h200);   // 01, a wrapped counter would read 11
    fpc = 32'h100; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b0, 32'h104}) begin
      $display("FAIL sat_nowrap got hit=%b pred=%b npc=%h want 1 0 00000104", hit, pred, next_pc);
    end else passed++;
    upd(32'h100, 1'b1, 32'h200);   // 10
    #1;
    total++;
    if (pred !== 1'b1) begin
      $display("FAIL sat_recover got pred=%b want 1", pred);
    end else passed++;
  endtask

  task automatic test_alias();
    do_reset();
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h140, 1'b1, 32'h300);
    fpc = 32'h100; #1;
    total++;
    if ({hit, next_pc} !== {1'b0, 32'h104}) begin
      $display("FAIL alias_evicted got hit=%b npc=%h want 0 00000104", hit, next_pc);
    end else passed++;
    upd(32'h180, 1'b0, 32'h0);
    fpc = 32'h140; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b1, 32'h300}) begin
      $display("FAIL alias_owner got hit=%b pred=%b npc=%h want 1 1 00000300", hit, pred, next_pc);
    end else passed++;
  endtask

  task automatic test_gating();
    do_reset();
    upd(32'h100, 1'b1, 32'h200);
    stall = 1'b1;
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h500, 1'b1, 32'h600);
    stall = 1'b0;
    fpc = 32'h100; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b1, 32'h200}) begin
      $display("FAIL stall_hold got hit=%b pred=%b npc=%h want 1 1 00000200", hit, pred, next_pc);
    end else passed++;
    fpc = 32'h500; #1;
    total++;
    if (hit !== 1'b0) begin
      $display("FAIL stall_noalloc got hit=%b want 0", hit);
    end else passed++;
    // Same-edge lookup sees the pre-update contents.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b0; upd_target = 32'h0;
    fpc = 32'h100; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b1, 32'h200}) begin
      $display("FAIL same_edge_old got hit=%b pred=%b npc=%h want 1 1 00000200", hit, pred, next_pc);
    end else passed++;
    tick();
    upd_valid = 1'b0;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b0, 32'h104}) begin
      $display("FAIL same_edge_new got hit=%b pred=%b npc=%h want 1 0 00000104", hit, pred, next_pc);
    end else passed++;
    clr = 1'b1;
    upd(32'h400, 1'b1, 32'h800);
    clr = 1'b0;
    fpc = 32'h100; #1;
    total++;
    if (hit !== 1'b0) begin
      $display("FAIL clr_invalidate got hit=%b want 0", hit);
    end else passed++;
    fpc = 32'h400; #1;
    total++;
    if ({hit, next_pc} !== {1'b0, 32'h404}) begin
      $display("FAIL clr_drop got hit=%b npc=%h want 0 00000404", hit, next_pc);
    end else passed++;
  endtask

  task automatic test_jalr_wrap();
    do_reset();
    fpc = 32'hFFFF_FFFC; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b0, 1'b0, 32'h0}) begin
      $display("FAIL pc_wrap got hit=%b pred=%b npc=%h want 0 0 00000000", hit, pred, next_pc);
    end else passed++;
    upd(32'h20, 1'b1, 32'h1235);
    fpc = 32'h20; #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b1, 1'b1, 32'h1234}) begin
      $display("FAIL jalr_target got hit=%b pred=%b npc=%h want 1 1 00001234", hit, pred, next_pc);
    end else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    upd(32'h100, 1'b1, 32'h200);
    upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h700;
    fpc = 32'h100;
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    total++;
    if ({hit, pred, next_pc} !== {1'b0, 1'b0, 32'h104}) begin
      $display("FAIL async_reset got hit=%b pred=%b npc=%h want 0 0 00000104", hit, pred, next_pc);
    end else passed++;
    @(posedge clk); #2;
    upd_valid = 1'b0;
    rstn = 1'b1;
    tick();
    fpc = 32'h300; #1;
    total++;
    if (hit !== 1'b0) begin
      $display("FAIL async_noalloc got hit=%b want 0", hit);
    end else passed++;
  endtask

  task automatic test_random();
    logic        eh, ep;
    logic [31:0] en;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_pc     = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 6) |
                   (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      upd_taken  = ($urandom_range(0, 2) != 0);
      upd_target = $urandom;
      stall      = ($urandom_range(0, 5) == 0);
      clr        = ($urandom_range(0, 60) == 0);
      fpc        = ($urandom_range(0, 1) != 0) ? upd_pc :
                   (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 6) |
                   (32'($urandom_range(0, 15)) << 2);
      #1;
      model_lookup(fpc, eh, ep, en);
      total++;
      if ({hit, pred, next_pc} !== {eh, ep, en}) begin
        $display("FAIL random n=%0d fpc=%h got hit=%b pred=%b npc=%h want %b %b %h",
                 n, fpc, hit, pred, next_pc, eh, ep, en);
      end else passed++;
      tick();
    end
    upd_valid = 1'b0; stall = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; clr = 1'b0; fpc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    model_reset();
    #1;
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_gating();
    test_jalr_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
